// File: rtl/register_uart_out_pkg.sv
// Shared types and widths for the register-to-UART output stage.
package register_uart_out_pkg;
   typedef enum logic [1:0] {UO_IDLE, UO_SEND, UO_DONE} uart_out_state_t;
   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;
endpackage

// File: rtl/register_uart_out_if.sv
// Issue-side controls and the byte handshake toward the UART transmitter.
interface register_uart_out_if;
   import register_uart_out_pkg::*;
   logic              distinct;
   logic              RegtoUART;
   logic [WORD_W-1:0] write_data;
   logic              output_ready;
   logic [BYTE_W-1:0] output_data;
   logic              output_valid;
   logic              pc_enable;
   logic              busy;

   modport master (output distinct, RegtoUART, write_data, output_ready,
                   input  output_data, output_valid, pc_enable, busy);
   modport slave  (input  distinct, RegtoUART, write_data, output_ready,
                   output output_data, output_valid, pc_enable, busy);
endinterface

// File: rtl/register_uart_out_serializer.sv
// Word load/shift register presenting one byte at a time, with a remaining-byte counter.
module register_uart_out_serializer
   import register_uart_out_pkg::*;
#(
   parameter int BYTES_PER_WORD = 1,
   parameter bit BIG_ENDIAN     = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] data_in,
   output logic [BYTE_W-1:0] byte_out,
   output logic              last
);
   // Big-endian loads left-justify the used bytes so the first byte is always on top.
   localparam int LSH = WORD_W - BYTE_W * BYTES_PER_WORD;

   logic [WORD_W-1:0] sr;
   logic [1:0]        cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= BIG_ENDIAN ? (data_in << LSH) : data_in;
         cnt <= 2'(BYTES_PER_WORD - 1);
      end else if (shift) begin
         sr  <= BIG_ENDIAN ? (sr << BYTE_W) : (sr >> BYTE_W);
         cnt <= cnt - 2'd1;
      end
   end

   assign byte_out = BIG_ENDIAN ? sr[WORD_W-1 -: BYTE_W] : sr[BYTE_W-1:0];
   assign last     = (cnt == 2'd0);
endmodule

// File: rtl/register_uart_out.sv
// Output-register-to-UART stage: latches a register, streams its bytes, stalls the PC meanwhile.
module register_uart_out
   import register_uart_out_pkg::*;
#(
   parameter int BYTES_PER_WORD = 1,
   parameter bit BIG_ENDIAN     = 1'b1
) (
   input  logic               CLK,
   input  logic               reset,
   register_uart_out_if.slave bus
);
   uart_out_state_t state;
   logic            req_buf;
   logic            valid_r, pc_en_r, busy_r;
   logic            load, shift, last, xfer;

   assign xfer  = valid_r && bus.output_ready;
   assign load  = (state == UO_IDLE) && bus.RegtoUART && !req_buf;
   assign shift = (state == UO_SEND) && xfer && !last;

   register_uart_out_serializer #(
      .BYTES_PER_WORD(BYTES_PER_WORD),
      .BIG_ENDIAN    (BIG_ENDIAN)
   ) u_ser (
      .clk     (CLK),
      .reset   (reset),
      .load    (load),
      .shift   (shift),
      .data_in (bus.write_data),
      .byte_out(bus.output_data),
      .last    (last)
   );

   // req_buf remembers a request already served so a held RegtoUART sends only once.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state   <= UO_IDLE;
         req_buf <= 1'b0;
         valid_r <= 1'b0;
         pc_en_r <= 1'b1;
         busy_r  <= 1'b0;
      end else begin
         case (state)
            UO_IDLE: begin
               if (bus.RegtoUART && !req_buf) begin
                  req_buf <= 1'b1;
                  valid_r <= 1'b1;
                  pc_en_r <= 1'b0;
                  busy_r  <= 1'b1;
                  state   <= UO_SEND;
               end else if (!bus.RegtoUART) begin
                  req_buf <= 1'b0;
               end
            end
            UO_SEND: begin
               if (xfer && last) begin
                  valid_r <= 1'b0;
                  pc_en_r <= 1'b1;
                  busy_r  <= 1'b0;
                  state   <= UO_DONE;
               end
            end
            UO_DONE: begin
               if (bus.distinct) begin
                  req_buf <= 1'b0;
                  state   <= UO_IDLE;
               end
            end
            default: state <= UO_IDLE;
         endcase
      end
   end

   assign bus.output_valid = valid_r;
   assign bus.pc_enable    = pc_en_r;
   assign bus.busy         = busy_r;
endmodule
